// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared fetch-path widths and the fetch buffer entry type
package rv_pkg;

  localparam int XLEN            = 32;
  localparam int IMEM_ADDR_WIDTH = 8;

  // One fetched instruction together with the word address it came from
  typedef struct packed {
    logic [IMEM_ADDR_WIDTH-1:0] pc;
    logic [XLEN-1:0]            instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-to-decode valid/ready instruction stream
interface instr_fetch_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  // Fetch side produces instructions
  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  // Decode side consumes instructions
  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - 2-entry in-order buffer of fetched instructions
module fetch_fifo
  import rv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  // Guard against overflow/underflow locally so the buffer is safe on its own
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

  // Storage, pointers and occupancy; flush drops contents but keeps storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner, ROM read master and buffered fetch front end
module instr_fetch
  import rv_pkg::*;
#(
  parameter int                    WIDTH      = XLEN,
  parameter int                    ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]      rom_instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  instr_fetch_if.master         dec
);

  logic [ADDR_WIDTH-1:0] pc;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  fetch_entry_t          wdata;
  fetch_entry_t          head;

  // Push eligibility looks only at registered occupancy so out_ready never
  // reaches the ROM address path
  assign push = enable && !redirect_valid && !full;
  assign pop  = !empty && dec.out_ready;

  assign wdata.pc    = pc;
  assign wdata.instr = rom_instr;

  assign rom_addr      = pc;
  assign dec.out_valid = !empty;
  assign dec.out_instr = head.instr;
  assign dec.out_pc    = head.pc;

  // Program counter: redirect wins, otherwise advance on each push (wraps)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_ADDR;
    end else if (redirect_valid) begin
      pc <= redirect_addr;
    end else if (push) begin
      pc <= pc + 1'b1;
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction-fetch front end and read-side master of the instruction ROM. It owns the program counter, drives the ROM word address, and captures the combinational ROM output with its PC into a 2-entry buffer. It presents fetched instructions to decode over a valid/ready handshake. It also accepts branch/jump redirects from execute, which flush the buffer.

Parameters:
WIDTH, 32, instruction width; must match the ROM data width.
ADDR_WIDTH, 8, ROM word-address width; the PC is a word address of this width.
RESET_ADDR, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
enable  input  1  fetch enable; when low, no new pushes occur and buffered entries still drain.
rom_addr  output  ADDR_WIDTH  word address to the ROM; equals the PC register.
rom_instr  input  WIDTH  combinational ROM read data for rom_addr.
out_valid  output  1  buffer head holds a valid instruction.
out_ready  input  1  decode accepts the head this cycle.
out_instr  output  WIDTH  instruction at the buffer head.
out_pc  output  ADDR_WIDTH  word address of out_instr.
redirect_valid  input  1  flush the buffer and load a new PC.
redirect_addr  input  ADDR_WIDTH  redirect target word address.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert by design):
  - pc=RESET_ADDR, count=0, all buffer entries zero.
  - out_valid=0, out_instr=0, out_pc=0, rom_addr=RESET_ADDR.
- rom_addr is driven only from the pc register, with no combinational path from any input.
- Definitions:
  - pop = out_valid && out_ready.
  - push = enable && !redirect_valid && (count < 2).
  - Push eligibility uses the registered count only; a pop in the same cycle does not free a slot. This keeps out_ready off the rom_addr path.
- On push at a clk edge:
  - Write {pc, rom_instr} to the tail.
  - pc <= pc + 1, modulo 2^ADDR_WIDTH; the wrap from 0xFF to 0x00 is silent.
- On pop: head advances.
- Push and pop in the same edge: count unchanged, and steady-state throughput is 1 instruction/cycle.
- Buffer is in-order FIFO, depth 2, count in {0,1,2}. out_valid = (count != 0). Head data is stable while out_valid && !out_ready.
- Redirect has priority over everything:
  - On an edge with redirect_valid=1: count <= 0, pc <= redirect_addr, no push.
  - A same-cycle pop is discarded; decode must not rely on it.
  - out_valid is 0 the cycle after a redirect.
- Latency:
  - Push edge N: out_valid=1 after edge N.
  - Redirect at edge R: rom_addr=target after R, the first push occurs at R+1, and out_valid=1 after R+1.
  - Reset release followed by edge 1 (enable=1): out_valid=1 with out_pc=RESET_ADDR.
- enable low: pc frozen, and the buffer drains normally. redirect_valid is still honoured.
- Back-to-back redirects: the last one wins, and no pushes occur between them.
- Reset mid-operation: all state returns immediately to reset values, and any in-flight entries are lost.
- No overflow is possible (push is gated by count). No underflow is possible (pop is gated by out_valid).

Decomposition:
- Shared package rv_pkg:
  - localparams XLEN=32 and IMEM_ADDR_WIDTH=8.
  - typedef fetch_entry_t, a packed struct {pc, instr}.
- Natural sub-module: fetch_fifo.
  - Generic 2-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - Asynchronous active-high reset.
- instr_fetch holds the PC, the push/redirect logic and the ROM interface.

Test Plan:
The ROM model drives rom_instr = 32'hC0DE0000 | rom_addr for every test.

1. Reset, then enable=1, out_ready=1 continuously: after edge 1, out_pc=0x00 and out_instr=0xC0DE0000. One new instruction per cycle follows: 0x01, 0x02, 0x03, with no bubbles.
2. out_ready=0 for 5 cycles from reset: count saturates at 2 and rom_addr holds 0x02. out_instr stays 0xC0DE0000. Raising out_ready then delivers 0x00, 0x01, 0x02 in order, with no loss or duplication.
3. Streaming past 0x05, assert redirect_valid with redirect_addr=0x31 for 1 cycle: the next cycle has out_valid=0 and rom_addr=0x31. The following cycle has out_pc=0x31 and out_instr=0xC0DE0031. Nothing from before the redirect appears afterwards.
4. Redirect to 0xFE, out_ready=1: out_pc sequence is 0xFE, 0xFF, 0x00, 0x01, showing the silent wrap.
5. enable=0 with 2 entries buffered and out_ready=1: 2 entries drain, then out_valid=0 and rom_addr is held. Re-enabling resumes from the held address.
6. Assert rst asynchronously mid-stream, between edges: out_valid=0, out_pc=0 and rom_addr=RESET_ADDR immediately, without waiting for clk. After release, test 1 behaviour repeats.
